math_divide_seq: RTL and testbench
==================================

# math_divide_seq

Parametrised sequential integer divider for the math library. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned per request, using a restoring radix-2 algorithm that retires one quotient bit per clock. A ready/start/done handshake lets a host FSM or datapath issue back-to-back divisions. Divide-by-zero and signed-overflow cases are flagged explicitly.

## Interface
- WIDTH, 32: operand and result width; legal range 2..64.
- SIGNED_EN, 1: 1 means `is_signed` is honoured; 0 means the sign logic is removed and all requests are unsigned.
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- start  in  1  request; sampled only when `ready`=1.
- is_signed  in  1  two's-complement mode for this request; sampled with `start`.
- dividend  in  WIDTH  numerator; sampled with `start`.
- divisor  in  WIDTH  denominator; sampled with `start`.
- ready  out  1  high in IDLE; a request can be accepted.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- div_by_zero  out  1  set with `done` when divisor==0; held with the results.

## Operation
- States are IDLE, RUN and FIN.
- IDLE:
  - start=1 captures the operands and mode, and clears done.
  - divisor==0 goes to FIN with the zero flag. Otherwise the FSM goes to RUN with counter=WIDTH.
- RUN (signed mode, entry):
  - Operands are converted to magnitudes.
  - The dividend sign (sd) and the quotient sign (sd XOR divisor sign) are recorded.
- RUN (each cycle):
  - Compute {rem,quo} <<= 1 with the next dividend MSB entering.
  - Trial = rem − |divisor|, computed at WIDTH+1 bits.
  - If trial ≥ 0, rem=trial and the quotient LSB=1; else the quotient LSB=0.
  - The counter decrements; reaching 0 moves to FIN.
- FIN:
  - Apply the sign fix: quotient is negated if the quotient sign is set; remainder is negated if sd is set, so the remainder sign follows the dividend.
  - Register the outputs, pulse done for one cycle, and return to IDLE.
- Divide by zero: quotient is all ones, remainder = dividend unmodified, div_by_zero=1.
- Signed overflow (MIN / −1): quotient=MIN, remainder=0, div_by_zero=0. This falls out of the magnitude arithmetic and needs no special path.
- Unsigned mode uses raw operands, with no negation at either end.
- start while not ready is ignored; there is no queueing.
- RST in any state:
  - Next state is IDLE.
  - quotient, remainder, done and div_by_zero are cleared to 0.
  - ready=1 in the cycle after the reset edge.
  - An in-flight division is discarded and produces no done.

## Timing
- Reset values: ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
- Normal latency: done is high WIDTH+1 cycles after the accepting edge (WIDTH RUN cycles, then 1 FIN cycle).
- Divide-by-zero latency: done is high 1 cycle after the accepting edge.
- ready=0 from the accepting edge until FIN completes. ready=1 in the same cycle done=1.
- A start asserted in the done cycle is accepted, giving back-to-back issue with one request every WIDTH+2 cycles.
- Outputs change only at FIN or reset and are stable between done pulses.

## Structure
- Shared package math_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - the divide-by-zero quotient constant (all ones, sized by WIDTH via a function).
- Sub-module math_divide_step is a combinational single restoring iteration. Inputs: rem, next dividend bit, divisor magnitude. Outputs: new rem, quotient bit. It is reusable by a future unrolled or pipelined divider.
- The top level holds the FSM, counter, sign capture/fix and output registers.

## Test plan
- WIDTH=32, unsigned 100/7: done at cycle 33 after accept; q=14, r=2, div_by_zero=0.
- Signed −7/2: q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Signed 7/−2: q=−3, r=1.
- 5/0 in either mode: done 1 cycle after accept; q=0xFFFFFFFF, r=5, div_by_zero=1.
- Signed 0x80000000/0xFFFFFFFF: q=0x80000000, r=0, div_by_zero=0.
- Assert RST at cycle 10 of a division: in the next cycle ready=1 and all outputs are 0. No done follows. A new request of 9/3 then gives q=3, r=0.
- start pulsed mid-RUN is ignored and the results match the first request. A start in the done cycle is accepted, and the second done arrives exactly 34 cycles after the first.

Source files
------------

// File: rtl/math_pkg.sv
// Shared definitions for the math library: divider FSM states and
// the divide-by-zero quotient pattern.
package math_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } div_state_e;

    // All-ones pattern of width w (1..64), returned in a 64-bit container.
    function automatic logic [63:0] dbz_quotient(input int unsigned w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/math_divide_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder and subtract the divisor if it fits.
module math_divide_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // The compare is the sign test of the (WIDTH+1)-bit trial subtraction;
    // when it passes, the difference is below the divisor and fits WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {1'b0, dvs_i});
        rem_o   = qbit_o ? (shifted[WIDTH-1:0] - dvs_i) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/math_divide_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock,
// with signed/unsigned mode and explicit divide-by-zero flag.
module math_divide_seq
    import math_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int          CW      = $clog2(WIDTH + 1);
    localparam logic [63:0] DBZ_Q64 = dbz_quotient(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sd_q, sd_d;
    logic             sq_q, sq_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             neg_a, neg_b;

    // quo_q doubles as the dividend shift register: its MSB feeds the step
    // and the new quotient bit enters at the LSB.
    math_divide_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        sd_d          = sd_q;
        sq_d          = sq_q;
        zero_d        = zero_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;
        neg_a         = SIGNED_EN && is_signed && dividend[WIDTH-1];
        neg_b         = SIGNED_EN && is_signed && divisor[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Preload the final values; FIN's sign fix is a no-op.
                        rem_d   = dividend;
                        quo_d   = DBZ_Q64[WIDTH-1:0];
                        sd_d    = 1'b0;
                        sq_d    = 1'b0;
                        zero_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        rem_d   = '0;
                        quo_d   = neg_a ? -dividend : dividend;
                        dvs_d   = neg_b ? -divisor : divisor;
                        sd_d    = neg_a;
                        sq_d    = neg_a ^ neg_b;
                        zero_d  = 1'b0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                quotient_d    = sq_q ? -quo_q : quo_q;
                remainder_d   = sd_q ? -rem_q : rem_q;
                div_by_zero_d = zero_q;
                done_d        = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            sd_q          <= 1'b0;
            sq_q          <= 1'b0;
            zero_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            sd_q          <= sd_d;
            sq_q          <= sq_d;
            zero_q        <= zero_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_math_divide_seq.sv
// Randomized self-checking bench for math_divide_seq against an arithmetic
// reference model (SV integer / and % on 64-bit values).
module tb_math_divide_seq;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_chk  = 0;
    int n_fail = 0;

    math_divide_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Truncating division: quotient toward zero, remainder takes dividend sign.
    task automatic ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, sq, sr;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q = sq[W-1:0]; r = sr[W-1:0]; z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    // Drive a request for one cycle; returns just after the accepting edge.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("ready_low_after_accept", ready, 1'b0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge CLK); #1;
            cyc++;
        end while (!done && cyc < 200);
        if (!done) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_result(input string tag, input bit s, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int cyc);
        logic [W-1:0] eq, er;
        logic         ez;
        ref_div(s, a, b, eq, er, ez);
        chk({tag, "_lat"}, cyc, (b == 0) ? 1 : W + 1);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        chk({tag, "_ready"}, ready, 1'b1);
    endtask

    task automatic run_one(input string tag, input bit s, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        int cyc;
        issue(s, a, b);
        wait_done(cyc);
        check_result(tag, s, a, b, cyc);
    endtask

    initial begin
        int cyc, ndone;
        bit s;
        logic [W-1:0] a, b;

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 1'b0);

        // Directed cases, also spot-checked against literal values
        run_one("u100_7", 1'b0, 32'd100, 32'd7);
        chk("u100_7_lit_q", quotient, 32'd14);
        chk("u100_7_lit_r", remainder, 32'd2);
        run_one("sm7_2", 1'b1, -32'sd7, 32'd2);
        chk("sm7_2_lit_q", quotient, 32'hFFFF_FFFD);
        chk("sm7_2_lit_r", remainder, 32'hFFFF_FFFF);
        run_one("s7_m2", 1'b1, 32'd7, -32'sd2);
        chk("s7_m2_lit_r", remainder, 32'd1);
        run_one("u5_0", 1'b0, 32'd5, 32'd0);
        run_one("s5_0", 1'b1, 32'd5, 32'd0);
        chk("s5_0_lit_q", quotient, 32'hFFFF_FFFF);
        run_one("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("smin_m1_lit_q", quotient, 32'h8000_0000);
        run_one("umin_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_one("sm1_0", 1'b1, 32'hFFFF_FFFF, 32'd0);

        // Reset in the middle of a division
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_dbz", div_by_zero, 1'b0);
        ndone = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        run_one("post_rst_9_3", 1'b0, 32'd9, 32'd3);

        // start pulsed while busy must be ignored
        issue(1'b0, 32'd1234, 32'd10);
        repeat (5) @(posedge CLK);
        #1; is_signed = 1'b1; dividend = 32'd77; divisor = 32'd0; start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        wait_done(cyc);
        check_result("busy_start", 1'b0, 32'd1234, 32'd10, cyc + 6);
        ndone = 0;
        repeat (W + 4) begin
            @(posedge CLK); #1;
            if (done) ndone++;
        end
        chk("busy_start_no_extra_done", ndone, 0);

        // Back-to-back: accept in the done cycle
        run_one("b2b_first", 1'b0, 32'd100, 32'd7);
        issue(1'b1, -32'sd100, 32'd7);
        wait_done(cyc);
        chk("b2b_gap", cyc + 1, W + 2);
        check_result("b2b_second", 1'b1, -32'sd100, 32'd7, cyc);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin s = 1'b1; a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'($urandom_range(0, 50)); b = $urandom; end
                4: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_one($sformatf("rnd%0d", i), s, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
